// File: rtl/read_flash_control.sv
`timescale 1ns/1ps
// read_flash_control: read-side page controller. On each en_read request it
// fetches one logged data page from NAND into the shared page RAM, chasing the
// write pointer, skipping bad blocks and honouring the per-block info page.
module read_flash_control #(
   parameter int PAGE_BYTES   = 8192,
   parameter int INFO_PAGE    = 127,
   parameter int MAX_BAD_SKIP = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_read,
   output logic        end_read,
   output logic [1:0]  read_status,
   output logic        en_read_page,
   input  logic        end_read_page,
   input  logic        read_data_valid,
   input  logic [7:0]  read_data,
   input  logic [13:0] read_data_cnt,
   output logic [23:0] read_addr_row,
   output logic        en_check_block,
   input  logic [1:0]  read_addr_row_error,
   input  logic [23:0] write_addr_row,
   input  logic [23:0] init_addr_row,
   input  logic        en_init_flash_addr,
   output logic        end_init_flash_addr,
   output logic        read_en_ram,
   output logic [14:0] read_ram_addr,
   output logic [7:0]  read_ram_datain
);

   localparam int               BAD_W        = $clog2(MAX_BAD_SKIP + 1);
   localparam logic [BAD_W-1:0] BAD_MAX      = BAD_W'(MAX_BAD_SKIP);
   localparam logic [BAD_W-1:0] BAD_ONE      = BAD_W'(1);
   localparam logic [6:0]       INFO_ROW     = 7'(INFO_PAGE);
   localparam logic [13:0]      PAGE_BYTES_W = 14'(PAGE_BYTES);

   typedef enum logic [3:0] {
      IDLE, CHK_EMPTY, CHK_BLK, WAIT_BLK, RD_INFO,
      WAIT_INFO, RD_PAGE, WAIT_PAGE, ADVANCE, DONE
   } state_t;

   state_t           state_reg;
   logic [23:0]      row_reg;
   logic [6:0]       page_limit_reg;
   logic [BAD_W-1:0] bad_cnt_reg;
   logic [7:0]       info_v_reg;
   logic             en_read_page_reg;
   logic             en_check_block_reg;
   logic             end_read_reg;
   logic [1:0]       read_status_reg;
   logic             end_init_reg;

   logic [11:0]      blk_next;
   logic [23:0]      row_next_blk;
   logic [6:0]       page_inc;
   logic [BAD_W-1:0] bad_inc;
   logic [7:0]       info_v_now;
   logic             page_phase;
   logic             unused_hi_bits;

   // Upper write-pointer bits never take part in the empty comparison.
   assign unused_hi_bits = ^write_addr_row[23:19];

   assign blk_next     = row_reg[18:7] + 12'd1;
   assign row_next_blk = {row_reg[23:19], blk_next, 7'd0};
   assign page_inc     = row_reg[6:0] + 7'd1;
   assign bad_inc      = bad_cnt_reg + BAD_ONE;
   // Byte 0 may arrive in the same cycle as end_read_page, so look through the latch.
   assign info_v_now   = (read_data_valid && read_data_cnt == 14'd0) ? read_data : info_v_reg;
   assign page_phase   = (state_reg == RD_PAGE) || (state_reg == WAIT_PAGE);

   // RAM write path is combinational; spare bytes and info-page bytes are dropped.
   assign read_en_ram     = page_phase && read_data_valid && (read_data_cnt < PAGE_BYTES_W);
   assign read_ram_addr   = page_phase ? {2'b00, read_data_cnt[12:0]} : 15'd0;
   assign read_ram_datain = page_phase ? read_data : 8'd0;

   assign end_read            = end_read_reg;
   assign read_status         = read_status_reg;
   assign en_read_page        = en_read_page_reg;
   assign read_addr_row       = row_reg;
   assign en_check_block      = en_check_block_reg;
   assign end_init_flash_addr = end_init_reg;

   // Main controller FSM with registered outputs and the read row pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg          <= IDLE;
         row_reg            <= 24'd0;
         page_limit_reg     <= INFO_ROW;
         bad_cnt_reg        <= '0;
         info_v_reg         <= 8'hFF;
         en_read_page_reg   <= 1'b0;
         en_check_block_reg <= 1'b0;
         end_read_reg       <= 1'b0;
         read_status_reg    <= 2'd0;
         end_init_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (en_init_flash_addr && !end_init_reg) begin
                  row_reg      <= init_addr_row;
                  end_init_reg <= 1'b1;
               end else if (end_init_reg) begin
                  if (!en_init_flash_addr) end_init_reg <= 1'b0;
               end else if (en_read) begin
                  state_reg <= CHK_EMPTY;
               end
            end
            CHK_EMPTY: begin
               if (row_reg[18:0] == write_addr_row[18:0]) begin
                  read_status_reg <= 2'd2;
                  end_read_reg    <= 1'b1;
                  state_reg       <= DONE;
               end else if (row_reg[6:0] == 7'd0) begin
                  state_reg <= CHK_BLK;
               end else begin
                  state_reg <= RD_PAGE;
               end
            end
            CHK_BLK: begin
               en_check_block_reg <= 1'b1;
               state_reg          <= WAIT_BLK;
            end
            WAIT_BLK: begin
               if (read_addr_row_error == 2'd1) begin
                  en_check_block_reg <= 1'b0;
                  bad_cnt_reg        <= '0;
                  row_reg            <= {row_reg[23:7], INFO_ROW};
                  state_reg          <= RD_INFO;
               end else if (read_addr_row_error == 2'd2) begin
                  en_check_block_reg <= 1'b0;
                  row_reg            <= row_next_blk;
                  if (bad_inc == BAD_MAX) begin
                     // Start the next request with a fresh skip budget.
                     bad_cnt_reg     <= '0;
                     read_status_reg <= 2'd3;
                     end_read_reg    <= 1'b1;
                     state_reg       <= DONE;
                  end else begin
                     bad_cnt_reg <= bad_inc;
                     state_reg   <= CHK_EMPTY;
                  end
               end
            end
            RD_INFO: begin
               en_read_page_reg <= 1'b1;
               info_v_reg       <= 8'hFF;
               state_reg        <= WAIT_INFO;
            end
            WAIT_INFO: begin
               if (read_data_valid && read_data_cnt == 14'd0) info_v_reg <= read_data;
               if (end_read_page) begin
                  en_read_page_reg <= 1'b0;
                  if (info_v_now == 8'h00) begin
                     row_reg   <= row_next_blk;
                     state_reg <= CHK_EMPTY;
                  end else begin
                     row_reg        <= {row_reg[23:7], 7'd0};
                     page_limit_reg <= (info_v_now == 8'hFF) ? INFO_ROW : info_v_now[6:0];
                     state_reg      <= RD_PAGE;
                  end
               end
            end
            RD_PAGE: begin
               en_read_page_reg <= 1'b1;
               state_reg        <= WAIT_PAGE;
            end
            WAIT_PAGE: begin
               if (end_read_page) begin
                  en_read_page_reg <= 1'b0;
                  state_reg        <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (page_inc == page_limit_reg) row_reg <= row_next_blk;
               else                            row_reg <= {row_reg[23:7], page_inc};
               read_status_reg <= 2'd1;
               end_read_reg    <= 1'b1;
               state_reg       <= DONE;
            end
            DONE: begin
               end_read_reg    <= 1'b0;
               read_status_reg <= 2'd0;
               if (!en_read) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_read_flash_control.sv
`timescale 1ns/1ps
// tb_read_flash_control: scoreboard bench with behavioural NAND basic module
// and bad-block checker models.
module tb_read_flash_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_read = 1'b0;
   logic        end_read;
   logic [1:0]  read_status;
   logic        en_read_page;
   logic        end_read_page = 1'b0;
   logic        read_data_valid = 1'b0;
   logic [7:0]  read_data = 8'd0;
   logic [13:0] read_data_cnt = 14'd0;
   logic [23:0] read_addr_row;
   logic        en_check_block;
   logic [1:0]  read_addr_row_error = 2'd0;
   logic [23:0] write_addr_row = 24'd0;
   logic [23:0] init_addr_row = 24'd0;
   logic        en_init_flash_addr = 1'b0;
   logic        end_init_flash_addr;
   logic        read_en_ram;
   logic [14:0] read_ram_addr;
   logic [7:0]  read_ram_datain;

   read_flash_control dut (
      .clk(clk), .rst(rst), .en_read(en_read), .end_read(end_read),
      .read_status(read_status), .en_read_page(en_read_page),
      .end_read_page(end_read_page), .read_data_valid(read_data_valid),
      .read_data(read_data), .read_data_cnt(read_data_cnt),
      .read_addr_row(read_addr_row), .en_check_block(en_check_block),
      .read_addr_row_error(read_addr_row_error), .write_addr_row(write_addr_row),
      .init_addr_row(init_addr_row), .en_init_flash_addr(en_init_flash_addr),
      .end_init_flash_addr(end_init_flash_addr), .read_en_ram(read_en_ram),
      .read_ram_addr(read_ram_addr), .read_ram_datain(read_ram_datain)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Flash content model
   bit         bad_blk [32];
   logic [7:0] info_val [32];
   int         page_len = 16;

   function automatic logic [7:0] pat(input logic [23:0] r, input logic [13:0] c);
      logic [7:0] r3;
      r3 = r[7:0] * 8'd3;
      return r3 ^ c[7:0] ^ {2'b00, c[13:8]};
   endfunction

   // Basic NAND module model: streams bytes, pushes expected RAM writes
   bit          bm_busy = 0, bm_need_low = 0, bm_info = 0;
   logic [23:0] bm_row = 0, last_data_row = 0;
   int          bm_idx = 0, bm_len = 0, page_starts = 0, info_starts = 0;
   logic [22:0] ram_q [$];

   always @(posedge clk) begin
      #1;
      read_data_valid = 1'b0;
      end_read_page   = 1'b0;
      if (rst) begin
         bm_busy = 0; bm_need_low = 0;
      end else if (bm_busy) begin
         if (bm_idx < bm_len) begin
            read_data_valid = 1'b1;
            read_data_cnt   = 14'(bm_idx);
            if (bm_info) read_data = (bm_idx == 0) ? info_val[bm_row[11:7]] : 8'h00;
            else         read_data = pat(bm_row, 14'(bm_idx));
            if (!bm_info && bm_idx < 8192) ram_q.push_back({2'b00, read_data_cnt[12:0], read_data});
            bm_idx++;
         end else begin
            end_read_page = 1'b1;
            bm_busy = 0; bm_need_low = 1;
         end
      end else if (bm_need_low) begin
         if (!en_read_page) bm_need_low = 0;
      end else if (en_read_page) begin
         bm_busy = 1; bm_row = read_addr_row; bm_idx = 0;
         bm_info = (read_addr_row[6:0] == 7'd127);
         bm_len  = bm_info ? 4 : page_len;
         if (bm_info) info_starts++;
         else begin page_starts++; last_data_row = read_addr_row; end
      end
   end

   // Bad-block checker model: answers two cycles after the request
   int chk_dly = 0, chk_starts = 0;
   bit chk_prev = 0;
   always @(posedge clk) begin
      #1;
      if (rst || !en_check_block) begin
         read_addr_row_error = 2'd0; chk_dly = 0;
      end else if (chk_dly < 2) chk_dly++;
      else read_addr_row_error = bad_blk[read_addr_row[11:7]] ? 2'd2 : 2'd1;
      if (en_check_block && !chk_prev) chk_starts++;
      chk_prev = en_check_block;
   end

   // Request scoreboard
   typedef struct packed { logic [1:0] st; logic [23:0] row; } req_t;
   req_t req_q [$];
   int   done_seen = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rst && read_en_ram) begin
         logic [22:0] e;
         check_eq("ram_q_nonempty", ram_q.size() != 0, 1);
         if (ram_q.size() != 0) begin
            e = ram_q.pop_front();
            check_eq("ram_write", {read_ram_addr, read_ram_datain}, e);
         end
      end
      if (!rst && read_data_valid && read_data_cnt[13])
         check_eq("spare_no_ram", read_en_ram, 0);
      if (!rst && end_read) begin
         req_t r;
         check_eq("req_q_nonempty", req_q.size() != 0, 1);
         if (req_q.size() != 0) begin
            r = req_q.pop_front();
            check_eq("read_status", read_status, r.st);
            check_eq("row_after", read_addr_row, r.row);
         end
         done_seen++;
      end
   end

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic do_init(input logic [23:0] a);
      int n;
      init_addr_row = a;
      en_init_flash_addr = 1'b1;
      n = 0;
      while (!end_init_flash_addr && n < 20) begin step(); n++; end
      check_eq("init_ack", end_init_flash_addr, 1);
      en_init_flash_addr = 1'b0;
      n = 0;
      while (end_init_flash_addr && n < 5) begin step(); n++; end
      check_eq("init_ack_clear", end_init_flash_addr, 0);
      check_eq("init_row", read_addr_row, a);
   endtask

   task automatic do_read(input logic [1:0] st, input logic [23:0] row, input int max_cyc);
      int d0, t0;
      d0 = done_seen; t0 = cyc;
      req_q.push_back({st, row});
      en_read = 1'b1;
      while (done_seen == d0 && (cyc - t0) < max_cyc) step();
      check_eq("end_read_seen", done_seen - d0, 1);
      if (done_seen == d0) req_q.delete();
      $display("read req exp_status=%0d exp_row=0x%06h got_row=0x%06h cycles=%0d",
               st, row, read_addr_row, cyc - t0);
      step();
      check_eq("end_read_pulse", end_read, 0);
      en_read = 1'b0;
      step(); step();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, i0, p0, n;
      for (int b = 0; b < 32; b++) begin bad_blk[b] = 0; info_val[b] = 8'hFF; end
      rst = 1'b1;
      repeat (3) step();
      check_eq("rst_en_read_page", en_read_page, 0);
      check_eq("rst_end_read", end_read, 0);
      check_eq("rst_row", read_addr_row, 0);
      check_eq("rst_en_check", en_check_block, 0);
      check_eq("rst_end_init", end_init_flash_addr, 0);
      check_eq("rst_ram_en", read_en_ram, 0);
      rst = 1'b0;
      step();

      // Full page with spare bytes, good open block
      page_len = 8196;
      write_addr_row = 24'h000085;
      do_init(24'h000080);
      c0 = chk_starts; i0 = info_starts; p0 = page_starts;
      do_read(2'd1, 24'h000081, 20000);
      check_eq("t1_chk_cnt", chk_starts - c0, 1);
      check_eq("t1_info_cnt", info_starts - i0, 1);
      check_eq("t1_page_cnt", page_starts - p0, 1);
      check_eq("t1_page_row", last_data_row, 24'h000080);
      check_eq("t1_ram_drained", ram_q.size(), 0);
      page_len = 16;

      // Empty: read caught up with write
      write_addr_row = 24'h000203;
      do_init(24'h000203);
      c0 = chk_starts; p0 = page_starts; i0 = info_starts;
      do_read(2'd2, 24'h000203, 3);
      check_eq("t2_no_page", page_starts + info_starts - p0 - i0, 0);
      check_eq("t2_no_chk", chk_starts - c0, 0);

      // One bad block then good
      write_addr_row = 24'h040000;
      bad_blk[2] = 1;
      do_init(24'h000100);
      c0 = chk_starts; i0 = info_starts;
      do_read(2'd1, 24'h000181, 2000);
      check_eq("t3_page_row", last_data_row, 24'h000180);
      check_eq("t3_chk_cnt", chk_starts - c0, 2);
      check_eq("t3_info_cnt", info_starts - i0, 1);
      bad_blk[2] = 0;

      // Skip limit
      for (int b = 4; b < 12; b++) bad_blk[b] = 1;
      do_init(24'h000200);
      c0 = chk_starts; p0 = page_starts; i0 = info_starts;
      do_read(2'd3, 24'h000600, 2000);
      check_eq("t4_chk_cnt", chk_starts - c0, 8);
      check_eq("t4_no_page", page_starts + info_starts - p0 - i0, 0);
      for (int b = 4; b < 12; b++) bad_blk[b] = 0;

      // Empty block (info byte 0) is skipped
      info_val[13] = 8'h00;
      do_init(24'h000680);
      i0 = info_starts;
      do_read(2'd1, 24'h000701, 2000);
      check_eq("t4b_page_row", last_data_row, 24'h000700);
      check_eq("t4b_info_cnt", info_starts - i0, 2);

      // Page limit from info byte 5
      info_val[1] = 8'h05;
      do_init(24'h000080);
      for (int i = 0; i < 5; i++)
         do_read(2'd1, (i < 4) ? 24'(24'h81 + i) : 24'h000100, 2000);
      check_eq("t5_last_row", last_data_row, 24'h000084);

      // Reset during WAIT_PAGE
      do_init(24'h000300);
      en_read = 1'b1;
      n = 0;
      while (!(bm_busy && !bm_info && bm_idx > 3) && n < 200) begin step(); n++; end
      check_eq("t6_in_page", bm_busy && !bm_info, 1);
      rst = 1'b1;
      @(posedge clk); #2;
      check_eq("t6_en_read_page", en_read_page, 0);
      check_eq("t6_row", read_addr_row, 0);
      check_eq("t6_end_read", end_read, 0);
      check_eq("t6_en_check", en_check_block, 0);
      check_eq("t6_ram_en", read_en_ram, 0);
      check_eq("t6_status", read_status, 0);
      en_read = 1'b0;
      step();
      rst = 1'b0;
      ram_q.delete();
      step();
      do_init(24'h000300);
      do_read(2'd1, 24'h000301, 2000);
      check_eq("t6_page_row", last_data_row, 24'h000300);

      check_eq("ram_q_drained", ram_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
